// File: rtl/tl_pkg.sv
// tl_pkg: shared state encodings and lamp constants
// for the N-phase traffic-light controller.
package tl_pkg;

   localparam int MAX_PHASE = 8;

   typedef enum logic [2:0] {
      ST_START  = 3'b111,
      ST_GREEN  = 3'b011,
      ST_YELLOW = 3'b010,
      ST_ALLRED = 3'b000,
      ST_FLASH  = 3'b001
   } tl_state_e;

   localparam logic [MAX_PHASE-1:0] LAMP_ALL = '1;
   localparam logic [MAX_PHASE-1:0] LAMP_OFF = '0;

endpackage

// File: rtl/tl_timer.sv
// tl_timer: loadable down-counter, flags zero,
// holds at zero until reloaded.
module tl_timer #(
   parameter int                   T_WIDTH = 8,
   parameter logic [T_WIDTH-1:0]   RST_VAL = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic [T_WIDTH-1:0] i_value,
   output logic               o_zero
);

   logic [T_WIDTH-1:0] r_cnt;

   // load on request, otherwise count down and stick at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= RST_VAL;
      else if (i_load)
         r_cnt <= i_value;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: N-phase traffic-light FSM with demand
// skipping, all-red clearance and flashing night mode.
module tl_phase_ctrl
   import tl_pkg::*;
#(
   parameter int  N_PHASE    = 3,
   parameter int  T_WIDTH    = 8,
   parameter int  Y_TIME     = 3,
   parameter int  AR_TIME    = 2,
   parameter int  FLASH_HALF = 4,
   localparam int PW         = $clog2(N_PHASE)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_PHASE*T_WIDTH-1:0] i_green_time,
   input  logic [N_PHASE-1:0]         i_req,
   input  logic                       i_flash,
   output logic [N_PHASE-1:0]         o_red,
   output logic [N_PHASE-1:0]         o_yellow,
   output logic [N_PHASE-1:0]         o_green,
   output logic [2:0]                 o_state,
   output logic [PW-1:0]              o_phase,
   output logic                       o_evt
);

   localparam logic [T_WIDTH-1:0] Y_LD  = T_WIDTH'(Y_TIME - 1);
   localparam logic [T_WIDTH-1:0] AR_LD = T_WIDTH'(AR_TIME - 1);
   localparam logic [T_WIDTH-1:0] FH_LD = T_WIDTH'(FLASH_HALF - 1);

   tl_state_e          r_state;
   tl_state_e          w_nx_state;
   logic [PW-1:0]      r_phase;
   logic [PW-1:0]      w_nx_phase;
   logic [PW-1:0]      w_srch;
   logic [PW-1:0]      w_gsel;
   logic [T_WIDTH-1:0] w_gt;
   logic [T_WIDTH-1:0] w_g_ld;
   logic               r_flash_on;
   logic               w_nx_flash;
   logic               r_evt;
   logic               w_evt;
   logic               w_zero;
   logic               w_load;
   logic [T_WIDTH-1:0] w_ld_val;
   logic [N_PHASE-1:0] r_red;
   logic [N_PHASE-1:0] r_yellow;
   logic [N_PHASE-1:0] r_green;
   logic [N_PHASE-1:0] w_red;
   logic [N_PHASE-1:0] w_yellow;
   logic [N_PHASE-1:0] w_green;

   tl_timer #(
      .T_WIDTH (T_WIDTH),
      .RST_VAL (AR_LD)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_value (w_ld_val),
      .o_zero  (w_zero)
   );

   // rotate from p+1: first phase with demand, phase 0 always eligible
   always_comb begin
      int            q;
      logic          found;
      logic [PW-1:0] qi;
      q      = 0;
      qi     = '0;
      found  = 1'b0;
      w_srch = '0;
      for (int k = 1; k <= N_PHASE; k++) begin
         q  = (int'(r_phase) + k) % N_PHASE;
         qi = PW'(q);
         if (!found && (q == 0 || i_req[qi])) begin
            found  = 1'b1;
            w_srch = qi;
         end
      end
   end

   // green time of the phase about to be entered; 0 acts as 1
   always_comb begin
      w_gsel = (r_state == ST_ALLRED) ? w_srch : '0;
      w_gt   = '0;
      for (int p = 0; p < N_PHASE; p++)
         if (w_gsel == PW'(p))
            w_gt = i_green_time[p*T_WIDTH +: T_WIDTH];
      w_g_ld = (w_gt == '0) ? '0 : w_gt - 1'b1;
   end

   // next-state, timer reload and entry-pulse logic
   always_comb begin
      w_nx_state = r_state;
      w_nx_phase = r_phase;
      w_nx_flash = r_flash_on;
      w_load     = 1'b0;
      w_ld_val   = '0;
      w_evt      = 1'b0;
      case (r_state)
         ST_START: if (w_zero) begin
            w_load = 1'b1;
            w_evt  = 1'b1;
            if (i_flash) begin
               w_nx_state = ST_FLASH;
               w_nx_flash = 1'b1;
               w_ld_val   = FH_LD;
            end else begin
               w_nx_state = ST_GREEN;
               w_nx_phase = '0;
               w_ld_val   = w_g_ld;
            end
         end
         ST_GREEN: if (w_zero) begin
            w_nx_state = ST_YELLOW;
            w_load     = 1'b1;
            w_ld_val   = Y_LD;
            w_evt      = 1'b1;
         end
         ST_YELLOW: if (w_zero) begin
            w_nx_state = ST_ALLRED;
            w_load     = 1'b1;
            w_ld_val   = AR_LD;
            w_evt      = 1'b1;
         end
         ST_ALLRED: if (w_zero) begin
            w_load = 1'b1;
            w_evt  = 1'b1;
            if (i_flash) begin
               w_nx_state = ST_FLASH;
               w_nx_flash = 1'b1;
               w_ld_val   = FH_LD;
            end else begin
               w_nx_state = ST_GREEN;
               w_nx_phase = w_srch;
               w_ld_val   = w_g_ld;
            end
         end
         ST_FLASH: if (w_zero) begin
            w_load = 1'b1;
            if (i_flash) begin
               w_nx_flash = ~r_flash_on;
               w_ld_val   = FH_LD;
            end else begin
               w_nx_state = ST_START;
               w_nx_phase = '0;
               w_ld_val   = AR_LD;
               w_evt      = 1'b1;
            end
         end
         default: begin
            w_nx_state = ST_START;
            w_nx_phase = '0;
            w_nx_flash = 1'b1;
            w_load     = 1'b1;
            w_ld_val   = AR_LD;
            w_evt      = 1'b1;
         end
      endcase
   end

   // lamp pattern for the upcoming state, registered below
   always_comb begin
      w_red    = LAMP_ALL[N_PHASE-1:0];
      w_yellow = LAMP_OFF[N_PHASE-1:0];
      w_green  = LAMP_OFF[N_PHASE-1:0];
      case (w_nx_state)
         ST_GREEN: begin
            w_red[w_nx_phase]   = 1'b0;
            w_green[w_nx_phase] = 1'b1;
         end
         ST_YELLOW: begin
            w_red[w_nx_phase]    = 1'b0;
            w_yellow[w_nx_phase] = 1'b1;
         end
         ST_FLASH: begin
            w_red       = {N_PHASE{w_nx_flash}};
            w_red[0]    = 1'b0;
            w_yellow[0] = w_nx_flash;
         end
         default: ;
      endcase
   end

   // state, phase and all outputs registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_START;
         r_phase    <= '0;
         r_flash_on <= 1'b1;
         r_evt      <= 1'b0;
         r_red      <= LAMP_ALL[N_PHASE-1:0];
         r_yellow   <= LAMP_OFF[N_PHASE-1:0];
         r_green    <= LAMP_OFF[N_PHASE-1:0];
      end else begin
         r_state    <= w_nx_state;
         r_phase    <= w_nx_phase;
         r_flash_on <= w_nx_flash;
         r_evt      <= w_evt;
         r_red      <= w_red;
         r_yellow   <= w_yellow;
         r_green    <= w_green;
      end
   end

   assign o_red    = r_red;
   assign o_yellow = r_yellow;
   assign o_green  = r_green;
   assign o_state  = r_state;
   assign o_phase  = r_phase;
   assign o_evt    = r_evt;

endmodule
